pad_mux_sequencer: RTL and testbench
====================================

Name: pad_mux_sequencer

Overview:
- Sits directly downstream of the pad-control register block. Consumes its per-pad attribute and mux-select vectors and drives the pad ring.
- Makes every mux change break-before-make: the pad output is gated off, the mux is switched, and the output is re-enabled only after a settle window.
- Attributes are registered and passed through. One independent sequencer runs per pad.

Parameters:
- NUM_PAD, 64, number of pads; must match the pad-control instance.
- MUX_W, 4, mux-select width per pad.
- ATTR_W, 8, attribute width per pad.
- SETTLE_CYCLES, 4, cycles the output stays gated after the mux switches; legal range 1..255.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- pad_attributes_i  in  NUM_PAD x ATTR_W  attributes from pad control.
- pad_muxes_i  in  NUM_PAD x MUX_W  requested mux selects from pad control.
- pad_attributes_o  out  NUM_PAD x ATTR_W  registered attributes to the pad ring.
- pad_muxes_o  out  NUM_PAD x MUX_W  applied mux select (equals mux_q).
- pad_oe_en_o  out  NUM_PAD  output-enable gate, ANDed with peripheral OE at the pad; 1 = pass.
- pad_switch_done_o  out  NUM_PAD  1-cycle pulse when a pad returns to IDLE.
- busy_o  out  1  OR over all pads of (state != IDLE); combinational from state.

Behaviour:
- Per-pad state: IDLE, DRAIN, SETTLE. Per-pad registers: mux_q[MUX_W], pend_q[MUX_W], cnt_q[8].
- Reset (asynchronous, rst_ni=0):
  - state=SETTLE, cnt_q=SETTLE_CYCLES-1, mux_q=0, pend_q=0.
  - pad_attributes_o=0, pad_oe_en_o=0, pad_switch_done_o=0.
  - After release, every pad stays gated for SETTLE_CYCLES cycles, then enters IDLE with mux 0.
  - If pad_muxes_i[p]!=0 on the last reset-settle cycle, the pad is not re-enabled: it takes the SETTLE→DRAIN path below.
- pad_attributes_o: 1-cycle registered copy of pad_attributes_i; independent of pad state.
- pad_oe_en_o[p] = (state==IDLE), registered (state is a flop).
- IDLE:
  - If pad_muxes_i[p]!=mux_q: pend_q<=pad_muxes_i[p] and go to DRAIN. The output is gated from the next cycle; mux_q is unchanged.
  - Otherwise stay in IDLE.
- DRAIN (exactly 1 cycle, old mux still applied, output gated):
  - mux_q<=pad_muxes_i[p], sampled this cycle; the latest value wins over pend_q.
  - cnt_q<=SETTLE_CYCLES-1; go to SETTLE.
  - If the input has reverted to the old mux value, the full DRAIN+SETTLE sequence still runs; there is no shortcut.
- SETTLE:
  - If pad_muxes_i[p]!=mux_q (retarget): mux_q<=pad_muxes_i[p], cnt_q<=SETTLE_CYCLES-1, stay in SETTLE. The output is already gated, so no DRAIN is needed.
  - Else if cnt_q==0: go to IDLE and assert pad_switch_done_o[p] for the cycle in which state becomes IDLE.
  - Else cnt_q<=cnt_q-1.
  - For the reset-exit SETTLE, a mismatch on the final cycle goes to DRAIN, not IDLE.
- Timing for a single change applied when the pad is IDLE:
  - pad_oe_en_o is low for exactly SETTLE_CYCLES+1 cycles.
  - pad_muxes_o changes 2 cycles after the input edge. It is never observed with pad_oe_en_o=1 in the cycle it changes.
- Invariant: pad_muxes_o[p] may change only while pad_oe_en_o[p]=0 and only if pad_oe_en_o[p] was 0 in the previous cycle.
- Pads are fully independent. Simultaneous changes on several pads each sequence in parallel; busy_o covers all of them.
- Reset asserted mid-sequence immediately forces the reset values above, regardless of current state.

Test Plan:
1. Reset release, SETTLE_CYCLES=4, inputs all 0 → pad_oe_en_o=0 for 4 cycles, then all 1. pad_switch_done_o pulses once on every pad. busy_o falls in the same cycle.
2. Pad 5 IDLE, pad_muxes_i[5] 0→3 at cycle T → oe_en[5]=0 from T+1 to T+5. pad_muxes_o[5]=3 from T+2. oe_en[5]=1 and done[5]=1 at T+6. Other pads unaffected.
3. Retarget: pad 5 in SETTLE with mux 3, input changed to 7 at the 2nd SETTLE cycle → mux_q=7 next cycle, counter reloads, oe stays 0 a further 4 cycles, and only one done pulse occurs.
4. Revert during DRAIN: input 0→3, then back to 0 on the DRAIN cycle → mux_q=0, full 4-cycle settle, oe low for 5 cycles total, done pulses once.
5. Attribute change 0x00→0xA5 on pad 10, together with a mux change on pad 10 → pad_attributes_o[10]=0xA5 after exactly 1 cycle, independent of the sequence. Invariant assertion holds throughout.
6. Reset asserted on the 2nd SETTLE cycle of pad 5 → immediately oe=0, mux_o=0, done=0. After release, the 4-cycle reset settle repeats.

Source files
------------

// File: rtl/pad_mux_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pad_mux_sequencer
//  Description : Break-before-make sequencer between the pad-control register
//                block and the pad ring. Every change of a pad's mux select
//                first gates the pad output off for one cycle, then applies
//                the new select, then holds the gate for a settle window
//                before re-enabling the output. Attributes are registered
//                and passed straight through. One sequencer runs per pad.
//
//  Ports       : clk_i              system clock
//                rst_ni             asynchronous active-low reset
//                pad_attributes_i   per-pad attributes from pad control
//                pad_muxes_i        per-pad requested mux selects
//                pad_attributes_o   registered attributes to the pad ring
//                pad_muxes_o        applied mux select per pad
//                pad_oe_en_o        output-enable gate per pad (1 = pass)
//                pad_switch_done_o  1-cycle pulse when a pad returns to IDLE
//                busy_o             any pad not in IDLE
//
//  Revision    : 1.0  initial release
// ============================================================================
module pad_mux_sequencer #(
    parameter int NUM_PAD       = 64,
    parameter int MUX_W         = 4,
    parameter int ATTR_W        = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_PAD-1:0][ATTR_W-1:0]   pad_attributes_i,
    input  logic [NUM_PAD-1:0][MUX_W-1:0]    pad_muxes_i,
    output logic [NUM_PAD-1:0][ATTR_W-1:0]   pad_attributes_o,
    output logic [NUM_PAD-1:0][MUX_W-1:0]    pad_muxes_o,
    output logic [NUM_PAD-1:0]               pad_oe_en_o,
    output logic [NUM_PAD-1:0]               pad_switch_done_o,
    output logic                             busy_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_drain  = 2'd1;
    localparam logic [1:0] c_st_settle = 2'd2;

    // Counter runs reload..0, so the gate is held for SETTLE_CYCLES cycles.
    localparam logic [7:0] c_cnt_reload = 8'(SETTLE_CYCLES - 1);

    logic [NUM_PAD-1:0][ATTR_W-1:0] r_attr;
    logic [NUM_PAD-1:0]             w_busy;

    // ------------------------------------------------------------------------
    // Attribute pass-through: one register stage, independent of sequencing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_attr <= '0;
        end else begin
            r_attr <= pad_attributes_i;
        end
    end

    assign pad_attributes_o = r_attr;

    // ------------------------------------------------------------------------
    // Per-pad break-before-make sequencer
    // ------------------------------------------------------------------------
    genvar p;
    generate
        for (p = 0; p < NUM_PAD; p++) begin : g_pad
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [MUX_W-1:0] r_mux;
            logic [MUX_W-1:0] w_mux_nxt;
            logic [7:0]       r_cnt;
            logic [7:0]       w_cnt_nxt;
            // Set while the pad is in the settle window that follows reset;
            // a mismatch on the final cycle of that window must drain first.
            logic             r_boot;
            logic             w_boot_nxt;
            logic             r_done;
            logic             w_mismatch;
            logic             w_oe;
            logic             w_pad_busy;

            assign w_mismatch = (pad_muxes_i[p] != r_mux);

            // State register
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_state <= c_st_settle;
                    r_cnt   <= c_cnt_reload;
                    r_mux   <= '0;
                    r_boot  <= 1'b1;
                    r_done  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_mux   <= w_mux_nxt;
                    r_boot  <= w_boot_nxt;
                    // Pulse aligns with the first cycle the pad is back in IDLE.
                    r_done  <= (r_state == c_st_settle) && (w_state_nxt == c_st_idle);
                end
            end

            // Next-state logic
            always_comb begin
                w_state_nxt = r_state;
                w_mux_nxt   = r_mux;
                w_cnt_nxt   = r_cnt;
                w_boot_nxt  = r_boot;
                case (r_state)
                    c_st_idle: begin
                        if (w_mismatch) begin
                            w_state_nxt = c_st_drain;
                        end
                    end
                    c_st_drain: begin
                        // Latest requested value is applied, even if it has
                        // reverted to the current one; the full settle still runs.
                        w_mux_nxt   = pad_muxes_i[p];
                        w_cnt_nxt   = c_cnt_reload;
                        w_state_nxt = c_st_settle;
                    end
                    c_st_settle: begin
                        if (w_mismatch && r_boot && (r_cnt == 8'd0)) begin
                            w_state_nxt = c_st_drain;
                            w_boot_nxt  = 1'b0;
                        end else if (w_mismatch) begin
                            // Output already gated: retarget without a drain.
                            w_mux_nxt = pad_muxes_i[p];
                            w_cnt_nxt = c_cnt_reload;
                        end else if (r_cnt == 8'd0) begin
                            w_state_nxt = c_st_idle;
                            w_boot_nxt  = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt - 8'd1;
                        end
                    end
                    default: begin
                        // Unreachable encoding: recover into a gated settle.
                        w_state_nxt = c_st_settle;
                        w_cnt_nxt   = c_cnt_reload;
                    end
                endcase
            end

            // Output logic (decoded from the state flop only)
            always_comb begin
                w_oe       = (r_state == c_st_idle);
                w_pad_busy = (r_state != c_st_idle);
            end

            assign pad_oe_en_o[p]       = w_oe;
            assign pad_muxes_o[p]       = r_mux;
            assign pad_switch_done_o[p] = r_done;
            assign w_busy[p]            = w_pad_busy;
        end
    endgenerate

    assign busy_o = |w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pad_mux_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pad_mux_sequencer
//  Description : Self-checking bench for pad_mux_sequencer. Directed scenario
//                tasks with fixed expectations plus a randomized run checked
//                against a per-pad behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pad_mux_sequencer;

    localparam int NP = 64;
    localparam int MW = 4;
    localparam int AW = 8;
    localparam int SC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic [NP-1:0][AW-1:0]     attr_in;
    logic [NP-1:0][MW-1:0]     mux_in;
    logic [NP-1:0][AW-1:0]     attr_out;
    logic [NP-1:0][MW-1:0]     mux_out;
    logic [NP-1:0]             oe;
    logic [NP-1:0]             done;
    logic                      busy;

    int n_checks = 0;
    int n_pass   = 0;

    // previous-cycle snapshot for the break-before-make invariant
    logic [NP-1:0]             prev_oe;
    logic [NP-1:0][MW-1:0]     prev_mux;

    // behavioural model: enabled flag, drain pending, settle cycles left
    bit          m_en    [NP];
    bit          m_drain [NP];
    bit          m_boot  [NP];
    bit          m_done  [NP];
    int          m_left  [NP];
    logic [MW-1:0] m_mux [NP];
    logic [AW-1:0] m_attr[NP];

    pad_mux_sequencer #(
        .NUM_PAD       (NP),
        .MUX_W         (MW),
        .ATTR_W        (AW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pad_attributes_i  (attr_in),
        .pad_muxes_i       (mux_in),
        .pad_attributes_o  (attr_out),
        .pad_muxes_o       (mux_out),
        .pad_oe_en_o       (oe),
        .pad_switch_done_o (done),
        .busy_o            (busy)
    );

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            m_en[p]    = 1'b0;
            m_drain[p] = 1'b0;
            m_boot[p]  = 1'b1;
            m_done[p]  = 1'b0;
            m_left[p]  = SC;
            m_mux[p]   = '0;
            m_attr[p]  = '0;
        end
    endfunction

    // One clock of the rules: an enabled pad seeing a new request loses its
    // gate for a drain cycle, then the newest request is applied and SC gated
    // cycles follow; any new request while gated restarts the SC window.
    function automatic void model_step();
        logic [MW-1:0] v;
        for (int p = 0; p < NP; p++) begin
            v         = mux_in[p];
            m_done[p] = 1'b0;
            m_attr[p] = attr_in[p];
            if (m_en[p]) begin
                if (v != m_mux[p]) begin
                    m_en[p]    = 1'b0;
                    m_drain[p] = 1'b1;
                end
            end else if (m_drain[p]) begin
                m_mux[p]   = v;
                m_drain[p] = 1'b0;
                m_left[p]  = SC;
            end else if (v != m_mux[p]) begin
                if (m_boot[p] && m_left[p] == 1) begin
                    m_drain[p] = 1'b1;
                    m_boot[p]  = 1'b0;
                end else begin
                    m_mux[p]  = v;
                    m_left[p] = SC;
                end
            end else if (m_left[p] == 1) begin
                m_en[p]   = 1'b1;
                m_boot[p] = 1'b0;
                m_done[p] = 1'b1;
            end else begin
                m_left[p] = m_left[p] - 1;
            end
        end
    endfunction

    task automatic tick();
        prev_oe  = oe;
        prev_mux = mux_out;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    function automatic logic [NP-1:0] inv_violations();
        logic [NP-1:0] viol;
        viol = '0;
        for (int p = 0; p < NP; p++)
            if (mux_out[p] != prev_mux[p] && (oe[p] || prev_oe[p])) viol[p] = 1'b1;
        return viol;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n   = 1'b0;
        mux_in  = '0;
        attr_in = {(NP*AW/32){32'h5AC3_96E1}};
        model_reset();
        repeat (2) tick();
        n_checks++; if (oe !== '0) $display("FAIL reset_oe: got %h want 0", oe); else n_pass++;
        n_checks++; if (mux_out !== '0) $display("FAIL reset_mux: got %h want 0", mux_out); else n_pass++;
        n_checks++; if (done !== '0) $display("FAIL reset_done: got %h want 0", done); else n_pass++;
        n_checks++; if (attr_out !== '0) $display("FAIL reset_attr: got %h want 0", attr_out); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
        attr_in = '0;
        rst_n   = 1'b1;
        for (int k = 1; k <= SC; k++) begin
            tick();
            n_checks++;
            if (oe !== ((k == SC) ? {NP{1'b1}} : {NP{1'b0}}))
                $display("FAIL boot_oe k=%0d: got %h", k, oe);
            else n_pass++;
            n_checks++;
            if (busy !== (k != SC)) $display("FAIL boot_busy k=%0d: got %b want %b", k, busy, k != SC);
            else n_pass++;
            n_checks++;
            if (done !== ((k == SC) ? {NP{1'b1}} : {NP{1'b0}}))
                $display("FAIL boot_done k=%0d: got %h", k, done);
            else n_pass++;
        end
        tick();
        n_checks++; if (done !== '0) $display("FAIL boot_done_once: got %h want 0", done); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_change();
        logic [NP-1:0] others;
        mux_in[5] = 4'd3;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (oe[5] !== (k >= 6)) $display("FAIL single_oe k=%0d: got %b want %b", k, oe[5], k >= 6);
            else n_pass++;
            n_checks++;
            if (mux_out[5] !== ((k >= 2) ? 4'd3 : 4'd0))
                $display("FAIL single_mux k=%0d: got %h want %h", k, mux_out[5], (k >= 2) ? 4'd3 : 4'd0);
            else n_pass++;
            n_checks++;
            if (done[5] !== (k == 6)) $display("FAIL single_done k=%0d: got %b want %b", k, done[5], k == 6);
            else n_pass++;
            others    = oe;
            others[5] = 1'b1;
            n_checks++;
            if (others !== {NP{1'b1}}) $display("FAIL single_others k=%0d: got %h", k, oe);
            else n_pass++;
            n_checks++;
            if (inv_violations() !== '0) $display("FAIL single_invariant k=%0d: got %h want 0", k, inv_violations());
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_retarget();
        int n_done;
        logic [MW-1:0] exp_mux;
        mux_in[5] = 4'd0;
        repeat (7) tick();
        n_checks++; if (mux_out[5] !== 4'd0) $display("FAIL retarget_pre: got %h want 0", mux_out[5]); else n_pass++;
        mux_in[5] = 4'd3;
        n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) mux_in[5] = 4'd7;
            if (done[5]) n_done++;
            exp_mux = (k >= 4) ? 4'd7 : ((k >= 2) ? 4'd3 : 4'd0);
            n_checks++;
            if (mux_out[5] !== exp_mux) $display("FAIL retarget_mux k=%0d: got %h want %h", k, mux_out[5], exp_mux);
            else n_pass++;
            n_checks++;
            if (oe[5] !== (k >= 8)) $display("FAIL retarget_oe k=%0d: got %b want %b", k, oe[5], k >= 8);
            else n_pass++;
            n_checks++;
            if (done[5] !== (k == 8)) $display("FAIL retarget_done k=%0d: got %b want %b", k, done[5], k == 8);
            else n_pass++;
        end
        n_checks++; if (n_done != 1) $display("FAIL retarget_done_count: got %0d want 1", n_done); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_revert();
        int n_done;
        int n_low;
        mux_in[5] = 4'd0;
        repeat (7) tick();
        mux_in[5] = 4'd3;
        n_done = 0;
        n_low  = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) mux_in[5] = 4'd0;
            if (done[5]) n_done++;
            if (!oe[5]) n_low++;
            n_checks++;
            if (mux_out[5] !== 4'd0) $display("FAIL revert_mux k=%0d: got %h want 0", k, mux_out[5]);
            else n_pass++;
            n_checks++;
            if (oe[5] !== (k >= 6)) $display("FAIL revert_oe k=%0d: got %b want %b", k, oe[5], k >= 6);
            else n_pass++;
        end
        n_checks++; if (n_low != SC + 1) $display("FAIL revert_low_count: got %0d want %0d", n_low, SC + 1); else n_pass++;
        n_checks++; if (n_done != 1) $display("FAIL revert_done_count: got %0d want 1", n_done); else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_attr();
        attr_in[10] = 8'h00;
        tick();
        attr_in[10] = 8'hA5;
        mux_in[10]  = 4'd2;
        #1;
        n_checks++; if (attr_out[10] !== 8'h00) $display("FAIL attr_early: got %h want 00", attr_out[10]); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (attr_out[10] !== 8'hA5) $display("FAIL attr_value k=%0d: got %h want a5", k, attr_out[10]);
            else n_pass++;
            n_checks++;
            if (oe[10] !== (k >= 6)) $display("FAIL attr_oe k=%0d: got %b want %b", k, oe[10], k >= 6);
            else n_pass++;
            n_checks++;
            if (inv_violations() !== '0) $display("FAIL attr_invariant k=%0d: got %h want 0", k, inv_violations());
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        mux_in[5] = 4'd3;
        repeat (3) tick();
        n_checks++; if (oe[5] !== 1'b0 || mux_out[5] !== 4'd3)
            $display("FAIL midrst_pre: got oe=%b mux=%h want oe=0 mux=3", oe[5], mux_out[5]); else n_pass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (oe !== '0) $display("FAIL midrst_oe: got %h want 0", oe); else n_pass++;
        n_checks++; if (mux_out !== '0) $display("FAIL midrst_mux: got %h want 0", mux_out); else n_pass++;
        n_checks++; if (done !== '0) $display("FAIL midrst_done: got %h want 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else n_pass++;
        mux_in = '0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= SC + 1; k++) begin
            tick();
            n_checks++;
            if (oe !== ((k >= SC) ? {NP{1'b1}} : {NP{1'b0}})) $display("FAIL midrst_boot_oe k=%0d: got %h", k, oe);
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_boot_drain();
        logic [NP-1:0] exp_done;
        rst_n  = 1'b0;
        mux_in = '0;
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (SC - 1) tick();
        mux_in[7] = 4'd9;
        for (int k = SC; k <= SC + 6; k++) begin
            tick();
            n_checks++;
            if (oe[7] !== (k >= SC + 5)) $display("FAIL bootdrain_oe k=%0d: got %b want %b", k, oe[7], k >= SC + 5);
            else n_pass++;
            n_checks++;
            if (mux_out[7] !== ((k >= SC + 1) ? 4'd9 : 4'd0)) $display("FAIL bootdrain_mux k=%0d: got %h", k, mux_out[7]);
            else n_pass++;
            exp_done    = (k == SC) ? {NP{1'b1}} : {NP{1'b0}};
            exp_done[7] = (k == SC + 5);
            n_checks++;
            if (done !== exp_done) $display("FAIL bootdrain_done k=%0d: got %h want %h", k, done, exp_done);
            else n_pass++;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        logic [NP-1:0]         e_oe;
        logic [NP-1:0]         e_done;
        logic [NP-1:0][MW-1:0] e_mux;
        logic [NP-1:0][AW-1:0] e_attr;
        rst_n  = 1'b0;
        mux_in = '0;
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (SC) tick();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 11) == 0) mux_in[p] = MW'($urandom);
                if ($urandom_range(0, 3) == 0) attr_in[p] = AW'($urandom);
            end
            tick();
            for (int p = 0; p < NP; p++) begin
                e_oe[p]   = m_en[p];
                e_done[p] = m_done[p];
                e_mux[p]  = m_mux[p];
                e_attr[p] = m_attr[p];
            end
            n_checks++; if (oe !== e_oe) $display("FAIL rand_oe c=%0d: got %h want %h", c, oe, e_oe); else n_pass++;
            n_checks++; if (mux_out !== e_mux) $display("FAIL rand_mux c=%0d: got %h want %h", c, mux_out, e_mux); else n_pass++;
            n_checks++; if (done !== e_done) $display("FAIL rand_done c=%0d: got %h want %h", c, done, e_done); else n_pass++;
            n_checks++; if (busy !== (e_oe != {NP{1'b1}})) $display("FAIL rand_busy c=%0d: got %b", c, busy); else n_pass++;
            n_checks++; if (attr_out !== e_attr) $display("FAIL rand_attr c=%0d: got %h want %h", c, attr_out, e_attr); else n_pass++;
            n_checks++;
            if (inv_violations() !== '0) $display("FAIL rand_invariant c=%0d: got %h want 0", c, inv_violations());
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        mux_in  = '0;
        attr_in = '0;
        #2;
        test_reset();
        test_single_change();
        test_retarget();
        test_revert();
        test_attr();
        test_reset_mid();
        test_boot_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
